// File: rtl/audio_pkg.sv
// Shared constants and types for the codec audio path (DAC serializer, future ADC deserializer).
package audio_pkg;

  localparam int SLOT_BITS            = 32;
  localparam int FRAME_SLOTS          = 64;
  localparam int SLOT_CNT_W           = $clog2(FRAME_SLOTS);
  localparam int SAMPLE_WIDTH_DEFAULT = 16;

  typedef logic signed [SAMPLE_WIDTH_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV clk cycles and flags the clk cycle
// in which each rising or falling transition is about to happen.
module audio_bclk_gen #(
  parameter int BCLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  logic [CNT_W-1:0] div_cnt_reg;
  logic             bclk_reg;
  logic             wrap;

  assign wrap = (div_cnt_reg == CNT_W'(BCLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
    end else if (wrap) begin
      div_cnt_reg <= '0;
      bclk_reg    <= ~bclk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // Strobes are combinational so the consumer acts on the same edge that moves bclk.
  assign bclk = bclk_reg;
  assign rise = wrap & ~bclk_reg;
  assign fall = wrap & bclk_reg;

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S transmitter: one stereo pair per 64-slot frame, codec as slave, single holding
// register between the upstream valid/ready handshake and the frame shift register.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int BCLK_DIV     = 8,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    aud_bclk,
  output logic                    aud_daclrck,
  output logic                    aud_dacdat,
  output logic                    frame_start,
  output logic                    underrun
);

  localparam int PAD_W   = SLOT_BITS - SAMPLE_WIDTH;
  localparam int FRAME_W = 2 * SLOT_BITS;

  logic                    bclk_rise;
  logic                    bclk_fall;
  logic [SLOT_CNT_W-1:0]   slot_cnt_reg;
  logic [SLOT_CNT_W-1:0]   slot_next;
  logic [FRAME_W-1:0]      shreg_reg;
  logic [FRAME_W-1:0]      frame_word;
  logic [SAMPLE_WIDTH-1:0] hold_left_reg;
  logic [SAMPLE_WIDTH-1:0] hold_right_reg;
  logic                    full_reg;
  logic                    lrck_reg;
  logic                    dacdat_reg;
  logic                    frame_start_reg;
  logic                    underrun_reg;
  logic                    xfer;
  logic                    load;

  audio_bclk_gen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_bclk_gen (
    .clk (clk),
    .rst (rst),
    .bclk(aud_bclk),
    .rise(bclk_rise),
    .fall(bclk_fall)
  );

  assign sample_ready = ~full_reg;
  assign xfer         = sample_valid & sample_ready;
  assign slot_next    = slot_cnt_reg + 1'b1;
  assign load         = bclk_fall & (slot_next == '0);

  // A held pair wins; otherwise a pair arriving in the load cycle bypasses the holding
  // register; otherwise the frame is silence.
  always_comb begin
    frame_word = '0;
    if (full_reg)
      frame_word = {hold_left_reg, {PAD_W{1'b0}}, hold_right_reg, {PAD_W{1'b0}}};
    else if (xfer)
      frame_word = {sample_left, {PAD_W{1'b0}}, sample_right, {PAD_W{1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_reg    <= '1;
      shreg_reg       <= '0;
      hold_left_reg   <= '0;
      hold_right_reg  <= '0;
      full_reg        <= 1'b0;
      lrck_reg        <= 1'b0;
      dacdat_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      frame_start_reg <= load;
      underrun_reg    <= load & ~full_reg & ~xfer;

      // Slot 0 carries the I2S one-bit delay, so the MSB leaves in slot 1.
      if (bclk_fall) begin
        slot_cnt_reg <= slot_next;
        lrck_reg     <= slot_next[SLOT_CNT_W-1];
        if (load) begin
          shreg_reg  <= frame_word;
          dacdat_reg <= 1'b0;
        end else begin
          dacdat_reg <= shreg_reg[FRAME_W-1];
          shreg_reg  <= {shreg_reg[FRAME_W-2:0], 1'b0};
        end
      end

      if (load) begin
        full_reg <= 1'b0;
      end else if (xfer) begin
        full_reg       <= 1'b1;
        hold_left_reg  <= sample_left;
        hold_right_reg <= sample_right;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(bclk_rise && bclk_fall));
  end

  assign aud_daclrck = lrck_reg;
  assign aud_dacdat  = dacdat_reg;
  assign frame_start = frame_start_reg;
  assign underrun    = underrun_reg;

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- Transmit end of the codec audio path: converts parallel stereo samples into the codec's I2S serial DAC stream.
- Runs on the 50 MHz system clock and generates its own bit clock (BCLK) and left/right clock (LRCK) with internal counters; the codec runs as slave.
- Upstream sample logic (mixer/playback) delivers one left/right pair per frame over a valid/ready handshake.

Parameters:
- BCLK_DIV, 8, half-period of BCLK in clk cycles; sample rate = 50e6 / (2 * BCLK_DIV * 64), about 48.8 kHz at 8. Legal range is 2 or more.
- SAMPLE_WIDTH, 16, bits per channel sample; legal range 1..31.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-high
- sample_left  in  SAMPLE_WIDTH  left sample, two's complement
- sample_right  in  SAMPLE_WIDTH  right sample
- sample_valid  in  1  the sample pair is presented
- sample_ready  out  1  block can accept a pair this cycle
- aud_bclk  out  1  serial bit clock to codec
- aud_daclrck  out  1  LRCK; 0 = left, 1 = right
- aud_dacdat  out  1  serial data, MSB first, I2S
- frame_start  out  1  one-cycle pulse when a frame is loaded
- underrun  out  1  one-cycle pulse when a frame is loaded with no sample available

Behaviour:
- Reset values: aud_bclk=0, aud_daclrck=0, aud_dacdat=0, frame_start=0, underrun=0. The holding register is empty, so sample_ready=1. div_cnt=0 and slot_cnt=63.
- div_cnt counts 0..BCLK_DIV-1. On wrap, aud_bclk toggles.
  - A wrap with bclk=0 is a rise event.
  - A wrap with bclk=1 is a fall event.
  - First rise is at clk edge BCLK_DIV after reset release; first fall is at edge 2*BCLK_DIV.
- Each fall event:
  - slot_cnt advances mod 64.
  - aud_daclrck is set to (new slot_cnt >= 32).
  - aud_dacdat updates.
- Data changes only on BCLK falls; the codec samples on BCLK rises.
- A frame is 64 slots with 32 slots per channel.
- Frame load happens at the fall event where slot_cnt becomes 0:
  - shreg(64b) is loaded with {L, zero pad, R, zero pad}; each channel occupies 32 bits with the sample left-aligned.
  - aud_dacdat is driven 0 for slot 0.
  - frame_start pulses in that same cycle.
- Each fall event with new slot 1..63: aud_dacdat takes shreg[63] and shreg shifts left by 1.
  - Result: slot 1 carries L MSB and slot 33 carries R MSB. This gives I2S one-BCLK delay after the LRCK edge.
  - Slots after the LSB carry 0.
- Handshake:
  - sample_ready = holding register empty.
  - Transfer occurs when sample_valid and sample_ready are both 1; the pair is captured into the holding register.
  - Inputs are ignored when ready=0.
  - Upstream must hold valid and data until the transfer.
- At frame load:
  - Holding register full: its contents load shreg, the register empties, and ready rises the next cycle.
  - Holding register empty and a transfer in the same cycle: bypass. The inputs load shreg directly, the holding register stays empty and underrun stays 0.
  - Holding register empty and no transfer: shreg loads all zeros (silence) and underrun pulses for 1 cycle.
- Latency: an accepted pair appears from the next frame load onward; its MSB is on aud_dacdat at slot 1 of that frame.
- Reset mid-operation forces all reset values asynchronously and discards the held sample and the partial frame. Timing after release is identical to power-up.

Decomposition:
- Package audio_pkg:
  - SLOT_BITS=32 and FRAME_SLOTS=64.
  - typedef sample_t logic signed [SAMPLE_WIDTH-1:0], with a package-level default of 16.
- Sub-module audio_bclk_gen:
  - Contains the div_cnt divider.
  - Outputs bclk plus the rise and fall strobes.
  - Reusable by a future ADC deserializer sharing BCLK/LRCK.

Test Plan (BCLK_DIV=2, SAMPLE_WIDTH=16, one frame = 256 clk):
- Reset release, no stimulus:
  - All outputs are 0 and sample_ready=1.
  - aud_bclk first rises at clk 2 and falls at clk 4.
  - frame_start and underrun pulse together at clk 4.
- Pair L=0xA5C3, R=0x0F0F is sent before the first load. Sample on bclk rises:
  - Slot 0 = 0; slots 1-16 = 1010010111000011; slots 17-31 = 0.
  - Slots 33-48 = 0000111100001111.
  - LRCK = 0 for slots 0-31 and 1 for slots 32-63.
  - underrun = 0.
- No sample for 3 frames -> underrun pulses exactly 3 times, one per frame, and aud_dacdat stays 0 throughout.
- Pairs P1 and P2 are offered back-to-back with valid held:
  - P1 is accepted and ready drops.
  - P2 is accepted 1 cycle after the next load.
  - Frames carry P1 then P2 in order.
- Valid is raised exactly in the load cycle with the holding register empty, L=0x8001 -> bypass: that frame's slot 1 = 1 and slot 16 = 1, underrun = 0, and ready stays 1.
- rst is asserted at slot 20 with a pair held:
  - All outputs go 0 in the same cycle, without waiting for a clock.
  - After release, the held pair is gone: the first frame is silent with underrun=1, and bclk timing matches power-up.
